// File: rtl/spi_voice_ctrl.sv
// SPI mode-0 slave register file driving per-voice NCO divider, phase offset,
// phase-apply and LFO-mode controls. SPI pins are oversampled in sys_clk.
module spi_voice_ctrl #(
    parameter int unsigned NUM_VOICES    = 4,
    parameter int unsigned NCO_ADDR_BITS = 8
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst,
    input  logic                                  spi_sck,
    input  logic                                  spi_cs_n,
    input  logic                                  spi_mosi,
    output logic                                  spi_miso,
    output logic [16*NUM_VOICES-1:0]              nco_divider,
    output logic [NCO_ADDR_BITS*NUM_VOICES-1:0]   phase_advance,
    output logic [NUM_VOICES-1:0]                 apply_phase_advance,
    output logic [NUM_VOICES-1:0]                 nco_lfo,
    output logic                                  frame_err
);

    localparam int unsigned CNT_W      = 5;
    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned DATA_W     = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [1:0]                 r_sck_s;
    logic [1:0]                 r_cs_s;
    logic [1:0]                 r_mosi_s;
    logic                       r_sck_h;
    logic                       r_cs_h;

    logic [CNT_W-1:0]           r_bit_cnt;
    logic [14:0]                r_shift;
    logic                       r_rw;
    logic [6:0]                 r_addr;
    logic [DATA_W-1:0]          r_miso_sr;
    logic                       r_miso_loaded;
    logic                       r_miso;
    logic                       r_frame_err;

    logic [DATA_W-1:0]          r_div   [NUM_VOICES];
    logic [NCO_ADDR_BITS-1:0]   r_phase [NUM_VOICES];
    logic [NUM_VOICES-1:0]      r_apply;
    logic [NUM_VOICES-1:0]      r_lfo;

    logic                       w_sck_rise;
    logic                       w_sck_fall;
    logic                       w_cs_fall;
    logic                       w_cs_rise;
    logic                       w_mosi;
    logic                       w_in_frame;
    logic                       w_cmd_done;
    logic                       w_frame_done;
    logic [DATA_W-1:0]          w_data;
    logic [DATA_W-1:0]          w_rd_data;

    // CS flops reset to "low" so a CS held low through reset cannot look like a fall
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sck_s  <= '0;
            r_cs_s   <= '0;
            r_mosi_s <= '0;
            r_sck_h  <= 1'b0;
            r_cs_h   <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[0], spi_sck};
            r_cs_s   <= {r_cs_s[0], spi_cs_n};
            r_mosi_s <= {r_mosi_s[0], spi_mosi};
            r_sck_h  <= r_sck_s[1];
            r_cs_h   <= r_cs_s[1];
        end
    end

    assign w_sck_rise = r_sck_s[1] & ~r_sck_h;
    assign w_sck_fall = ~r_sck_s[1] & r_sck_h;
    assign w_cs_fall  = ~r_cs_s[1] & r_cs_h;
    assign w_cs_rise  = r_cs_s[1] & ~r_cs_h;
    assign w_mosi     = r_mosi_s[1];
    assign w_data     = {r_shift, w_mosi};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Frame sequencing; CS rise always wins over a coincident SCK edge
    always_comb begin
        w_state_nxt  = r_state;
        w_in_frame   = 1'b0;
        w_cmd_done   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
            S_CMD: begin
                w_in_frame = 1'b1;
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sck_rise && r_bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                    w_cmd_done  = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_in_frame = 1'b1;
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sck_rise && r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: if (w_cs_rise) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_addr[6:2] == 5'(v)) begin
                case (r_addr[1:0])
                    2'd0:    w_rd_data = r_div[v];
                    2'd1:    w_rd_data = DATA_W'(r_phase[v]);
                    2'd2:    w_rd_data = {14'd0, r_apply[v], r_lfo[v]};
                    default: w_rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_rw          <= 1'b0;
            r_addr        <= '0;
            r_miso_sr     <= '0;
            r_miso_loaded <= 1'b0;
            r_miso        <= 1'b0;
            r_frame_err   <= 1'b0;
            r_apply       <= '0;
            r_lfo         <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_div[v]   <= 16'hFFFF;
                r_phase[v] <= '0;
            end
        end else begin
            r_frame_err <= w_in_frame & w_cs_rise;

            if (r_state == S_IDLE && w_cs_fall) begin
                r_bit_cnt     <= '0;
                r_miso_loaded <= 1'b0;
            end

            if (w_in_frame && w_sck_rise && !w_cs_rise) begin
                r_shift   <= {r_shift[13:0], w_mosi};
                r_bit_cnt <= CNT_W'(r_bit_cnt + CNT_W'(1));
            end

            if (w_cmd_done) begin
                r_rw   <= r_shift[6];
                r_addr <= {r_shift[5:0], w_mosi};
            end

            // Read word is captured on the first falling SCK of the data phase
            if (w_state_nxt != S_DATA) begin
                r_miso <= 1'b0;
            end else if (r_state == S_DATA && w_sck_fall && r_rw) begin
                if (!r_miso_loaded) begin
                    r_miso_sr     <= w_rd_data;
                    r_miso        <= w_rd_data[DATA_W-1];
                    r_miso_loaded <= 1'b1;
                end else begin
                    r_miso_sr <= {r_miso_sr[DATA_W-2:0], 1'b0};
                    r_miso    <= r_miso_sr[DATA_W-2];
                end
            end

            if (w_frame_done && !r_rw) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (r_addr[6:2] == 5'(v)) begin
                        case (r_addr[1:0])
                            2'd0: r_div[v]   <= w_data;
                            2'd1: r_phase[v] <= w_data[NCO_ADDR_BITS-1:0];
                            2'd2: begin
                                r_lfo[v]   <= w_data[0];
                                r_apply[v] <= w_data[1];
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign nco_divider[16*v +: 16]                      = r_div[v];
        assign phase_advance[NCO_ADDR_BITS*v +: NCO_ADDR_BITS] = r_phase[v];
    end

    assign apply_phase_advance = r_apply;
    assign nco_lfo             = r_lfo;
    assign spi_miso            = r_miso;
    assign frame_err           = r_frame_err;

endmodule

// File: tb/tb_spi_voice_ctrl.sv
// Scoreboard bench for spi_voice_ctrl: SPI master stimulus, expected output
// updates / read words / frame errors queued and checked by monitors.
module tb_spi_voice_ctrl;

    localparam int unsigned NV   = 4;
    localparam int unsigned AB   = 8;
    localparam int unsigned HALF = 8;

    typedef struct packed {
        logic [16*NV-1:0] div;
        logic [AB*NV-1:0] ph;
        logic [NV-1:0]    ap;
        logic [NV-1:0]    lfo;
    } snap_t;

    logic sys_clk = 1'b0;
    logic sys_rst, spi_sck, spi_cs_n, spi_mosi;
    logic spi_miso, frame_err;
    logic [16*NV-1:0] nco_divider;
    logic [AB*NV-1:0] phase_advance;
    logic [NV-1:0]    apply_phase_advance, nco_lfo;

    spi_voice_ctrl #(.NUM_VOICES(NV), .NCO_ADDR_BITS(AB)) dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .spi_sck             (spi_sck),
        .spi_cs_n            (spi_cs_n),
        .spi_mosi            (spi_mosi),
        .spi_miso            (spi_miso),
        .nco_divider         (nco_divider),
        .phase_advance       (phase_advance),
        .apply_phase_advance (apply_phase_advance),
        .nco_lfo             (nco_lfo),
        .frame_err           (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    last_rise_cyc = 0;
    int    bit_idx = 0;
    int    lat;
    logic  err_prev = 1'b0;
    logic [15:0] rd_word;
    logic [15:0] g_word;
    snap_t m, rst_snap, cur_snap, prev_snap, e_snap;

    snap_t       exp_out_q[$];
    logic [15:0] exp_rd_q[$];
    logic [15:0] got_rd_q[$];
    int          exp_err_q[$];

    assign cur_snap = {nco_divider, phase_advance, apply_phase_advance, nco_lfo};

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Output-update monitor: every change must match the next queued snapshot
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            prev_snap = cur_snap;
        end else if (cur_snap !== prev_snap) begin
            if (exp_out_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out_change got=%0h prev=%0h", cur_snap, prev_snap);
            end else begin
                e_snap = exp_out_q.pop_front();
                chk("out_update", 128'(cur_snap), 128'(e_snap));
                lat = cyc - last_rise_cyc;
                n_checks++;
                if (lat < 3 || lat > 5) begin
                    n_errors++;
                    $display("FAIL commit_latency got=%0d exp=3..5", lat);
                end
            end
            prev_snap = cur_snap;
        end
    end

    always @(negedge sys_clk) begin
        if (got_rd_q.size() > 0) begin
            g_word = got_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_read got=%0h exp=none", g_word);
            end else begin
                chk("read_data", 128'(g_word), 128'(exp_rd_q.pop_front()));
            end
        end
    end

    always @(negedge sys_clk) begin
        if (frame_err && !sys_rst) begin
            n_checks++;
            if (err_prev) begin
                n_errors++;
                $display("FAIL frame_err_width got=2+ exp=1");
            end else if (exp_err_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_frame_err got=1 exp=0");
            end else begin
                void'(exp_err_q.pop_front());
            end
        end
        err_prev = frame_err;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        bit_idx  = 0;
        rd_word  = '0;
        tick(4);
    endtask

    task automatic send_bits(input logic [31:0] vec, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = vec[i];
            tick(HALF);
            if (bit_idx >= 8 && bit_idx < 24) rd_word = {rd_word[14:0], spi_miso};
            if (bit_idx == 23) last_rise_cyc = cyc;
            spi_sck = 1'b1;
            bit_idx++;
            tick(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_end();
        tick(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tick(6);
    endtask

    task automatic model_write(input logic [23:0] f);
        int    v;
        snap_t old;
        old = m;
        v   = int'(f[22:18]);
        if (!f[23] && v < int'(NV)) begin
            case (f[17:16])
                2'd0: m.div[16*v +: 16] = f[15:0];
                2'd1: m.ph[AB*v +: AB]  = f[AB-1:0];
                2'd2: begin
                    m.lfo[v] = f[0];
                    m.ap[v]  = f[1];
                end
                default: ;
            endcase
        end
        if (m !== old) exp_out_q.push_back(m);
    endtask

    task automatic write_frame(input logic [23:0] f);
        model_write(f);
        cs_begin();
        send_bits(32'(f), 24);
        cs_end();
    endtask

    task automatic read_frame(input logic [6:0] addr, input logic [15:0] exp);
        exp_rd_q.push_back(exp);
        cs_begin();
        send_bits(32'({1'b1, addr, 16'h0000}), 24);
        cs_end();
        got_rd_q.push_back(rd_word);
    endtask

    task automatic do_reset(input int n);
        sys_rst = 1'b1;
        tick(n);
        sys_rst = 1'b0;
        m = rst_snap;
        tick(2);
    endtask

    task automatic checkpoint(input string name);
        tick(8);
        chk({name, "_outputs"}, 128'(cur_snap), 128'(m));
        chk({name, "_miso_idle"}, 128'(spi_miso), 128'(0));
        chk({name, "_pending_out"}, 128'(exp_out_q.size()), 128'(0));
        chk({name, "_pending_rd"}, 128'(exp_rd_q.size()), 128'(0));
        chk({name, "_pending_err"}, 128'(exp_err_q.size()), 128'(0));
    endtask

    initial begin
        sys_rst  = 1'b1;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        rst_snap = '{div: {NV{16'hFFFF}}, ph: '0, ap: '0, lfo: '0};
        m        = rst_snap;
        tick(2);
        sys_rst = 1'b0;
        tick(4);
        checkpoint("reset");

        write_frame(24'h081234);
        checkpoint("div_v2");
        chk("div_v2_slice", 128'(nco_divider[47:32]), 128'(16'h1234));

        write_frame(24'h060003);
        checkpoint("ctrl_v1");
        chk("ctrl_v1_bits", 128'({nco_lfo[1], apply_phase_advance[1]}), 128'(2'b11));
        read_frame(7'h06, 16'h0003);
        read_frame(7'h08, 16'h1234);
        checkpoint("readback");

        write_frame(24'h1500AB);
        checkpoint("oor_write");
        read_frame(7'h15, 16'h0000);
        write_frame(24'h0512AB);
        read_frame(7'h05, 16'h00AB);
        write_frame(24'h0BFFFF);
        read_frame(7'h0B, 16'h0000);
        checkpoint("phase_reserved");

        exp_err_q.push_back(1);
        cs_begin();
        send_bits(32'h045, 12);
        cs_end();
        checkpoint("abort");
        chk("abort_div_v1", 128'(nco_divider[31:16]), 128'(16'hFFFF));
        write_frame(24'h045678);
        read_frame(7'h04, 16'h5678);
        checkpoint("after_abort");

        model_write(24'h0C9ABC);
        cs_begin();
        send_bits(32'h0C9ABCFF, 32);
        cs_end();
        checkpoint("overlong");
        chk("overlong_div_v3", 128'(nco_divider[63:48]), 128'(16'h9ABC));

        cs_begin();
        send_bits(32'h004, 12);
        do_reset(2);
        send_bits(32'h321, 12);
        cs_end();
        checkpoint("rst_mid");
        write_frame(24'h004321);
        read_frame(7'h00, 16'h4321);
        checkpoint("after_rst");
        chk("after_rst_div_v0", 128'(nco_divider[15:0]), 128'(16'h4321));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_voice_ctrl.md
# spi_voice_ctrl

SPI-slave control register file that sits directly upstream of the per-voice NCOs in the synth datapath. It oversamples an external SPI mode-0 bus in the `sys_clk` domain and decodes fixed 24-bit frames into register writes and reads. It drives each voice NCO's divider, phase-offset, phase-apply and LFO-mode inputs from held registers.

## Interface
- `NUM_VOICES`, 4: number of NCO voices controlled; legal range 1..32.
- `NCO_ADDR_BITS`, 8: width of each voice's phase offset; legal range 1..16.

- `sys_clk`  in  1  system clock; must be at least 8x the SPI SCK frequency.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `spi_sck`  in  1  asynchronous SPI clock, mode 0, idle low.
- `spi_cs_n`  in  1  asynchronous chip select, active low.
- `spi_mosi`  in  1  asynchronous serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first; driven 0 when not returning read data.
- `nco_divider`  out  16*NUM_VOICES  per-voice divider; voice v occupies bits [16v+15:16v].
- `phase_advance`  out  NCO_ADDR_BITS*NUM_VOICES  per-voice phase offset; voice v occupies the v-th slice.
- `apply_phase_advance`  out  NUM_VOICES  per-voice phase-apply enable (level).
- `nco_lfo`  out  NUM_VOICES  per-voice LFO-mode flag.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- **Input synchronisation.** `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchroniser, followed by one history flop on SCK and CS. Edge detect produces `sck_rise`, `sck_fall` and `cs_fall`/`cs_rise` single-cycle strobes.
- **Frame format.** 24 bits:
  - bit 23 = R/W (1 = read);
  - bits 22:16 = addr[6:0];
  - bits 15:0 = data.
- **Address decode.**
  - addr[6:2] = voice index; addr[1:0] = register.
  - Register 0: `nco_divider` (16 bits).
  - Register 1: `phase_advance` (data[NCO_ADDR_BITS-1:0]; upper bits ignored on write, read as 0).
  - Register 2: control. Bit0 = `nco_lfo`, bit1 = `apply_phase_advance`; other bits ignored on write, read as 0.
  - Register 3: reserved. Writes are dropped; reads return 16'h0000.
  - Voice index >= NUM_VOICES: writes are dropped; reads return 16'h0000.
- **FSM states.**
  - IDLE: wait for `cs_fall`, then clear the bit counter and go to CMD.
  - CMD: shift MOSI on each `sck_rise`. After 8 bits, latch R/W and addr, then go to DATA.
  - DATA: shift MOSI on each `sck_rise`. After bit 24:
    - a write commits the 16-bit data to the addressed register;
    - a read commits nothing;
    - go to DONE.
  - DONE: ignore further SCK edges until `cs_rise`, then go to IDLE.
- **Abort.** `cs_rise` in CMD or DATA returns to IDLE, commits nothing and pulses `frame_err` for 1 cycle. `cs_rise` in DONE does not pulse `frame_err`.
- **Read path.**
  - On the first `sck_fall` after the 8th command bit, load the 16-bit read value into the MISO shifter and drive its MSB.
  - On each subsequent `sck_fall` in DATA, shift left.
  - `spi_miso` = 0 in IDLE, CMD and DONE.
- **Reset** (`sys_rst` high at a clock edge):
  - FSM goes to IDLE and the bit counter clears;
  - every `nco_divider` slice = 16'hFFFF;
  - all `phase_advance` = 0, `apply_phase_advance` = 0, `nco_lfo` = 0;
  - `spi_miso` = 0, `frame_err` = 0.
- **Reset mid-frame.** The frame is discarded and nothing is written. The block resynchronises on the next `cs_fall`.
- **CS already low out of reset.** No frame starts until CS goes high, then low again.

## Timing
- Input-to-strobe latency: 3 `sys_clk` cycles from a pin transition to the corresponding edge strobe.
- Write commit: the output register updates at the `sys_clk` edge ending the cycle in which the 24th `sck_rise` strobe is asserted, and is visible the cycle after. All fields of one register update in the same cycle.
- Outputs hold between writes. There are no glitches on unaddressed voices.
- `frame_err`: exactly 1 cycle, asserted the cycle after the `cs_rise` strobe.
- MISO becomes valid within 4 `sys_clk` cycles of the SCK pin falling edge. This meets mode-0 setup when the SCK period is >= 8 `sys_clk` cycles.
- Back-to-back frames are supported with CS high for >= 4 `sys_clk` cycles.

## Test plan
- **Reset values.** Assert `sys_rst` for 2 cycles. Required: all dividers = 16'hFFFF, all other outputs 0, `spi_miso` = 0.
- **Divider write, voice 2.** Write frame 0x08_1234 (addr 0x08 = voice 2, register 0). Required: `nco_divider[47:32]` = 16'h1234, one cycle after the 24th sampled bit; other voices unchanged.
- **Control write then read-back, voice 1.** Write frame 0x06_0003. Required: `nco_lfo[1]` = 1 and `apply_phase_advance[1]` = 1. Then read frame 0x86_xxxx. Required: MISO returns 16'h0003 MSB first.
- **Phase write to an out-of-range voice.** With NUM_VOICES = 4, write frame 0x15_00AB. Required: no output changes. A read of addr 0x15 returns 16'h0000.
- **Abort.** Raise CS after 12 bits of a write to addr 0x04. Required: `frame_err` pulses 1 cycle, `nco_divider[31:16]` stays 16'hFFFF, and the next full frame writes correctly.
- **Overlong frame and reset mid-frame.**
  - Send 32 bits in one CS window. Required: only the first 24 bits take effect and `frame_err` stays 0.
  - Assert `sys_rst` mid-frame. Required: no commit, and a subsequent frame succeeds.
